// File: rtl/ccip_almfull_monitor.sv
// Passive CCI-P almost-full compliance monitor: counts TX requests per almost-full window
// and records violations beyond MAX_IN_FLIGHT, plus worst burst and first-violation info.
module ccip_almfull_monitor #(
   parameter int unsigned NUM_CH        = 2,
   parameter int unsigned MAX_IN_FLIGHT = 8,
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned TS_W          = 32,
   localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    pClk,
   input  logic                    pck_cp2af_softReset_n,
   input  logic [NUM_CH-1:0]       alm_full_i,
   input  logic [NUM_CH-1:0]       tx_valid_i,
   input  logic                    clear_i,
   output logic [NUM_CH-1:0]       viol_o,
   output logic                    viol_any_o,
   output logic [NUM_CH-1:0]       err_pulse_o,
   output logic [CH_W-1:0]         first_ch_o,
   output logic [TS_W-1:0]         first_ts_o,
   output logic [NUM_CH*CNT_W-1:0] viol_cnt_o,
   output logic [NUM_CH*CNT_W-1:0] max_burst_o
);

   // Compare in at least 32 bits so a budget wider than the counter never truncates.
   localparam int unsigned CmpW = (CNT_W > 32) ? CNT_W : 32;

   logic [CNT_W-1:0]  win_q   [NUM_CH];
   logic [CNT_W-1:0]  win_d   [NUM_CH];
   logic [CNT_W-1:0]  vcnt_q  [NUM_CH];
   logic [CNT_W-1:0]  vcnt_d  [NUM_CH];
   logic [CNT_W-1:0]  mb_q    [NUM_CH];
   logic [CNT_W-1:0]  mb_d    [NUM_CH];
   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] viol_q, viol_d;
   logic [NUM_CH-1:0] err_q, err_d;
   logic              any_q, any_d;
   logic              rec_q, rec_d;
   logic [CH_W-1:0]   first_ch_q, first_ch_d;
   logic [TS_W-1:0]   first_ts_q, first_ts_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [CH_W-1:0]   low_ch;

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i] = alm_full_i[i] & tx_valid_i[i] &
                  (CmpW'(win_q[i]) >= CmpW'(MAX_IN_FLIGHT));
         if (!alm_full_i[i]) begin
            win_d[i] = '0;
         end else if (tx_valid_i[i] && (win_q[i] != '1)) begin
            win_d[i] = win_q[i] + CNT_W'(1);
         end else begin
            win_d[i] = win_q[i];
         end
      end
   end

   always_comb begin
      ts_d       = ts_q + TS_W'(1);
      err_d      = hit;
      rec_d      = clear_i ? 1'b0 : rec_q;
      first_ch_d = clear_i ? '0 : first_ch_q;
      first_ts_d = clear_i ? '0 : first_ts_q;
      low_ch     = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (hit[i]) low_ch = CH_W'(i);
      end
      for (int i = 0; i < NUM_CH; i++) begin
         viol_d[i] = (clear_i ? 1'b0 : viol_q[i]) | hit[i];
         vcnt_d[i] = clear_i ? '0 : vcnt_q[i];
         if (hit[i] && (vcnt_d[i] != '1)) vcnt_d[i] = vcnt_d[i] + CNT_W'(1);
         mb_d[i] = clear_i ? '0 : mb_q[i];
         if (win_d[i] > mb_d[i]) mb_d[i] = win_d[i];
      end
      // Capture only the first violation since reset or the last clear.
      if (!rec_d && (|hit)) begin
         rec_d      = 1'b1;
         first_ch_d = low_ch;
         first_ts_d = ts_q;
      end
      any_d = |viol_d;
   end

   always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n) begin
         win_q      <= '{default: '0};
         vcnt_q     <= '{default: '0};
         mb_q       <= '{default: '0};
         viol_q     <= '0;
         err_q      <= '0;
         any_q      <= 1'b0;
         rec_q      <= 1'b0;
         first_ch_q <= '0;
         first_ts_q <= '0;
         ts_q       <= '0;
      end else begin
         win_q      <= win_d;
         vcnt_q     <= vcnt_d;
         mb_q       <= mb_d;
         viol_q     <= viol_d;
         err_q      <= err_d;
         any_q      <= any_d;
         rec_q      <= rec_d;
         first_ch_q <= first_ch_d;
         first_ts_q <= first_ts_d;
         ts_q       <= ts_d;
      end
   end

   always_comb begin
      viol_cnt_o  = '0;
      max_burst_o = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         viol_cnt_o[i*CNT_W +: CNT_W]  = vcnt_q[i];
         max_burst_o[i*CNT_W +: CNT_W] = mb_q[i];
      end
   end

   assign viol_o      = viol_q;
   assign viol_any_o  = any_q;
   assign err_pulse_o = err_q;
   assign first_ch_o  = first_ch_q;
   assign first_ts_o  = first_ts_q;

endmodule

// File: doc/ccip_almfull_monitor.md
# ccip_almfull_monitor

- Parametrised, multi-channel CCI-P almost-full compliance monitor.
- Counts TX requests issued while a channel's almost-full is asserted and flags every request beyond a configurable budget.
- Records per-channel statistics: violation count, worst burst, and first-violation channel plus timestamp.
- Sits beside the AFU wrapper, taps the TX valid and almost-full signals passively, drives nothing back into CCI-P, and its outputs feed debug CSRs and simulation assertions.

## Interface
- NUM_CH, 2, number of monitored TX channels (c0, c1, ...); minimum 1
- MAX_IN_FLIGHT, 8, requests allowed per almost-full window before a violation
- CNT_W, 32, width of per-channel window, violation and max-burst counters
- TS_W, 32, width of free-running cycle timestamp
- CH_W, derived: max(1, $clog2(NUM_CH))
- pClk  in  1  sole clock, all state on rising edge
- pck_cp2af_softReset_n  in  1  asynchronous, active-low reset
- alm_full_i  in  NUM_CH  per-channel TxAlmFull
- tx_valid_i  in  NUM_CH  per-channel TX valid
- clear_i  in  1  synchronous clear of recorded statistics (not window state)
- viol_o  out  NUM_CH  sticky per-channel violation flag
- viol_any_o  out  1  OR of viol_o
- err_pulse_o  out  NUM_CH  one-cycle pulse per violating request
- first_ch_o  out  CH_W  channel of first recorded violation
- first_ts_o  out  TS_W  timestamp of first recorded violation
- viol_cnt_o  out  NUM_CH*CNT_W  saturating violating-request count, channel i at [i*CNT_W +: CNT_W]
- max_burst_o  out  NUM_CH*CNT_W  largest window count observed, same packing

## Operation

**Timestamp**
- ts: free-running counter, +1 every cycle, wraps modulo 2^TS_W.
- Not affected by clear_i.

**Window counter win[i]**
- If alm_full_i[i]=0: win[i] ← 0. A tx_valid_i[i] in that cycle is not counted.
- If alm_full_i[i]=1 and tx_valid_i[i]=1: win[i] ← win[i]+1, saturating at 2^CNT_W−1.
- Otherwise win[i] holds.

**Violation**
- Condition in cycle t: alm_full_i[i]=1, tx_valid_i[i]=1, and win[i] ≥ MAX_IN_FLIGHT. This makes the (MAX_IN_FLIGHT+1)-th and every later request in the window a violation.
- On a violation:
  - err_pulse_o[i]=1 in cycle t+1.
  - viol_o[i] set.
  - viol_cnt[i] +1, saturating.
- If no violation has been recorded since reset or the last clear:
  - first_ts ← ts value at cycle t.
  - first_ch ← lowest index among channels violating in cycle t.
- MAX_IN_FLIGHT=0: every request under almost-full violates.

**Max burst**
- max_burst[i] ← max(max_burst[i], next win[i]) every cycle.

**clear_i**
- Zeroes viol_o, viol_cnt, max_burst, first_ch, first_ts and the first-recorded flag.
- win[i] and ts are not cleared.
- Violation in the same cycle as clear_i: the violation is recorded on top of the cleared state (cnt=1, flag set, first_* captured). Same rule for max_burst: it takes next win.

**Reset**
- Asynchronous assertion, all registers go to 0: every output 0, win=0, ts=0.
- Reset mid-window discards the window.
- The first cycle after deassertion starts a fresh window.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Pipeline latency from offending cycle t:
  - err_pulse_o, viol_o, viol_any_o, viol_cnt_o, first_* valid at t+1.
  - max_burst_o valid at t+1.
- Channels are fully independent, except first_ch priority (lowest index wins on a tie).
- alm_full_i dropping and rising again in consecutive cycles starts a new window at 0.
- ts wrap is not an error. first_ts captures the wrapped value.
- Throughput: one request per channel per cycle, no back-pressure.

## Test plan
- NUM_CH=2, MAX=8: hold alm_full[0]=1, send 10 back-to-back valids on ch0 → err_pulse_o[0] high on exactly 2 cycles (after the 9th and 10th sends), viol_cnt[0]=2, max_burst[0]=10, viol_o=2'b01, first_ch=0.
- ch0 sends 8 under alm_full, alm_full drops 1 cycle, rises, 8 more sends → no violation, max_burst[0]=8, viol_o=0.
- Both channels cross the budget in the same cycle at ts=37 → first_ch=0, first_ts=37, viol_o=2'b11; a later ch1-only violation leaves first_* unchanged.
- Valid with alm_full=0 for 100 cycles → all counters 0. Then assert clear_i in the same cycle as a 9th-send violation → viol_cnt=1, first_ts=that cycle's ts, viol_o set.
- CNT_W=4, MAX=2: 20 sends under alm_full → win and viol_cnt saturate at 15, max_burst=15, no wrap.
- Assert reset_n low mid-window (win=5) with viol_o set → all outputs 0 asynchronously. After release, 8 sends → no violation.
